// File: rtl/key_event_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : key_event_queue_if
// Description : Bus bundle between the button-event source / CPU I/O port
//               and the key event queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_event_queue_if #(
  parameter int WIDTH = 20,
  parameter int AW    = 3
);
  logic [WIDTH-1:0] pause;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic [AW:0]      count;
  logic             irq;
  logic             overflow;
  logic             ovf_clr;

  // Environment side: event source plus CPU.
  modport master (
    output pause, rd_en, ovf_clr,
    input  rd_data, rd_valid, empty, full, count, irq, overflow
  );

  // Queue side.
  modport slave (
    input  pause, rd_en, ovf_clr,
    output rd_data, rd_valid, empty, full, count, irq, overflow
  );
endinterface
`default_nettype wire

// File: rtl/key_event_queue.sv
`default_nettype none
// ============================================================================
// Module      : key_event_queue
// Description : Captures every nonzero event word into a small FIFO until the
//               CPU pops it; flags pending (irq) and lost (overflow) events.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_queue #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  key_event_queue_if.slave  bus
);

  localparam logic [AW:0] C_FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] entry_q [DEPTH];

  logic w_push;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr;
  logic w_drop;

  // Decode push/pop; a full queue still accepts a push when a pop frees a slot
  // on the same edge, and an empty queue never bypasses a push to the reader.
  always_comb begin
    w_push  = |bus.pause;
    w_empty = (count_q == '0);
    w_full  = (count_q == C_FULL_CNT);
    w_pop   = bus.rd_en & ~w_empty;
    w_wr    = w_push & (~w_full | w_pop);
    w_drop  = w_push & w_full & ~w_pop;
  end

  // Next-state for pointers, occupancy, read port and sticky overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = w_pop;
    overflow_d = overflow_q;

    if (w_wr) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (w_pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      rd_data_d = entry_q[rd_ptr_q];
    end

    case ({w_wr, w_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // A drop on the same edge as a clear must leave the flag set.
    if (w_drop) begin
      overflow_d = 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  // Control and read-port registers; reset discards all queued events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage entries carry no reset; occupancy alone says which are live.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_d;

    // Load the event word when this slot is the write target.
    always_comb begin
      entry_d = entry_q[gi];
      if (w_wr && (wr_ptr_q == AW'(gi))) begin
        entry_d = bus.pause;
      end
    end

    // Entry register.
    always_ff @(posedge clk) begin
      entry_q[gi] <= entry_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.count    = count_q;
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.irq      = ~w_empty;
  assign bus.overflow = overflow_q;

endmodule
`default_nettype wire

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Consumer end of the button-event pulse stream.
- Captures every nonzero one-cycle event word on its input into a small FIFO, holding each event until the CPU pops it with a read strobe.
- Flags pending events, with a level suitable as an interrupt, and flags lost events.
- Sits between the button-change pulse generator and the CPU's I/O bus, in the same clock domain as both.

Parameters:
WIDTH, 20, width of one event word (one bit per button)
DEPTH, 8, FIFO entries; must be a power of two, at least 2
AW, 3, log2(DEPTH); pointer width

Ports:
clk  input  1  system clock; all logic on its rising edge
rst_n  input  1  asynchronous, active-low reset
pause  input  WIDTH  event pulse word; any nonzero value in a cycle is one event
rd_en  input  1  CPU pop strobe, one cycle per pop
rd_data  output  WIDTH  popped event word
rd_valid  output  1  one-cycle pulse: rd_data updated this cycle
empty  output  1  no events stored
full  output  1  DEPTH events stored
count  output  AW+1  number of stored events, 0..DEPTH
irq  output  1  event pending; equals !empty
overflow  output  1  sticky: at least one event dropped
ovf_clr  input  1  clears overflow

Behaviour:
- Reset (rst_n low, asynchronous):
  - write pointer, read pointer and count = 0
  - rd_data = 0, rd_valid = 0, overflow = 0
  - therefore empty = 1, full = 0, irq = 0
  - FIFO storage is not reset.
- Push condition: pause != 0 in a cycle.
  - The whole word is stored at the write pointer on that edge, and the write pointer increments modulo DEPTH.
  - pause == 0 never writes.
  - Each nonzero cycle is a separate event. Consecutive nonzero cycles give consecutive entries; there is no merging.
- Pop condition: rd_en = 1 and count != 0.
  - On that edge, rd_data <= entry at the read pointer, the read pointer increments modulo DEPTH, and rd_valid <= 1 for exactly one cycle.
  - Latency: rd_data and rd_valid are valid in the cycle after the rd_en cycle.
  - rd_en while empty is ignored: rd_valid <= 0, rd_data holds, pointers unchanged.
- rd_data holds its last popped value until the next successful pop.
- count update:
  - +1 on push only
  - -1 on pop only
  - unchanged on simultaneous push and pop, or on neither.
- empty = (count == 0); full = (count == DEPTH). Both are combinational from registered count. irq = !empty.
- Full boundary:
  - Push while full with no pop: the event is dropped, storage and pointers are untouched, overflow <= 1.
  - Push while full with a pop in the same cycle: both happen; the push is accepted, count stays DEPTH, overflow unchanged.
- Empty boundary:
  - Push and rd_en in the same cycle while empty: only the push happens (no bypass), count becomes 1, rd_valid stays 0.
  - The pushed event is poppable from the next cycle.
- overflow:
  - Set by a dropped event.
  - Cleared by ovf_clr = 1 on the next edge.
  - If a drop and ovf_clr coincide, the set wins (overflow = 1).
- Pointer wrap: pointers are AW bits and wrap naturally. FIFO order is preserved across wrap.
- Reset mid-operation: all stored events are discarded (count = 0). A pop in flight produces no rd_valid after reset releases.
- No combinational path from pause or rd_en to any output.

Test Plan:
- Reset, then three event pulses 20'h00001, 20'h00002, 20'h80000 on separate cycles -> count = 3, irq = 1. Three rd_en strobes -> rd_data 20'h00001, 20'h00002, 20'h80000 in order, each with a 1-cycle rd_valid one cycle after its rd_en; count = 0, empty = 1.
- rd_en with queue empty -> rd_valid stays 0, rd_data keeps its previous value, count stays 0.
- Ten consecutive nonzero pulses 1..10 with DEPTH = 8 -> full = 1 after 8, overflow = 1. Popping eight times yields 1..8. ovf_clr -> overflow = 0.
- Queue full, then push 20'h00AAA and rd_en in the same cycle -> oldest entry popped, 20'h00AAA accepted, count stays 8, overflow stays 0. 20'h00AAA is the last value drained.
- Interleave 20 pushes and pops with count kept between 1 and 3 -> both pointers wrap at least twice, and output order exactly matches input order.
- With 5 events queued, assert rst_n low for one cycle mid-pop -> count = 0, empty = 1, irq = 0, rd_valid = 0 immediately. Next push 20'h00004 pops back as 20'h00004.
